// File: rtl/pixel_pkg.sv
// Shared types and helpers for the frame-buffer pixel writer and its companion reader.
// Both blocks size their coordinate counters with the same helpers.
package pixel_pkg;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_CAPTURE = 2'd1,
    WR_FINISH  = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1,
    RD_DONE   = 2'd2
  } rd_state_e;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int img_size(input int w, input int h);
    return w * h;
  endfunction

  // A one-pixel dimension still needs a 1-bit coordinate register.
  function automatic int coord_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster-order pixel pointer with row/col tracking.
// The pointer saturates on the last pixel; the owner decides when to clear it.
module pixel_coord_counter
  import pixel_pkg::*;
#(
  parameter  int IMG_W  = 96,
  parameter  int IMG_H  = 96,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H),
  localparam int ROW_W  = coord_w(IMG_H),
  localparam int COL_W  = coord_w(IMG_W)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o,
  output logic              last_o
);

  localparam int IMG_SIZE = img_size(IMG_W, IMG_H);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;

  assign last_o = (ptr_q == ADDR_W'(IMG_SIZE - 1));

  always_comb begin
    ptr_d = ptr_q;
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      ptr_d = '0;
      row_d = '0;
      col_d = '0;
    end else if (inc_i && !last_o) begin
      ptr_d = ptr_q + ADDR_W'(1);
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign ptr_o = ptr_q;
  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/pixel_writer.sv
// Captures one frame of streamed pixels into a linear buffer, one registered write per accepted beat.
// in_ready is the only combinational output so upstream sees abort the same cycle.
module pixel_writer
  import pixel_pkg::*;
#(
  parameter  int IMG_W  = 96,
  parameter  int IMG_H  = 96,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        drop_count
);

  localparam int ROW_W = coord_w(IMG_H);
  localparam int COL_W = coord_w(IMG_W);

  wr_state_e         state_q, state_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic [7:0]        drop_q;

  logic              accept;
  logic              arm;
  logic              cnt_clear;
  logic              cnt_last;
  logic [ADDR_W-1:0] cnt_ptr;
  logic [ROW_W-1:0]  row_unused;
  logic [COL_W-1:0]  col_unused;

  assign in_ready  = (state_q == WR_CAPTURE) && !abort;
  assign accept    = in_valid && in_ready;
  assign arm       = (state_q == WR_IDLE) && start;
  assign cnt_clear = arm || ((state_q == WR_CAPTURE) && abort);

  pixel_coord_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_coord (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clear_i (cnt_clear),
    .inc_i   (accept),
    .ptr_o   (cnt_ptr),
    .row_o   (row_unused),
    .col_o   (col_unused),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE: begin
        if (start) state_d = WR_CAPTURE;
      end
      WR_CAPTURE: begin
        if (abort)                    state_d = WR_IDLE;
        else if (accept && cnt_last)  state_d = WR_FINISH;
      end
      WR_FINISH: state_d = WR_IDLE;
      default:   state_d = WR_IDLE;
    endcase
  end

  // done and the final write both land in the single Finish cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= WR_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_en_q <= accept;
      busy_q  <= (state_d != WR_IDLE);
      done_q  <= accept && cnt_last;
      if (accept) begin
        wr_addr_q <= cnt_ptr;
        wr_data_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (arm) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready && (drop_q != DROP_MAX)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Randomised and directed bench for pixel_writer on a 4x3 image.
// A frame-level reference model predicts every registered output one cycle ahead.
module tb_pixel_writer;

  localparam int IMG_W    = 4;
  localparam int IMG_H    = 3;
  localparam int DATA_W   = 8;
  localparam int IMG_SIZE = IMG_W * IMG_H;
  localparam int ADDR_W   = $clog2(IMG_SIZE);

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [7:0]        drop_count;

  int checks     = 0;
  int failures   = 0;
  int writesSeen = 0;
  int doneSeen   = 0;
  logic [DATA_W-1:0] lastFrame [IMG_SIZE];

  // Reference model: frame phase, next pixel index and drop tally.
  bit mCapturing = 1'b0;
  bit mFinishing = 1'b0;
  int mIndex     = 0;
  int mDrop      = 0;

  always #5 clk = ~clk;

  pixel_writer #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .drop_count (drop_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, predicts the outcome, then checks it after the edge.
  task automatic applyStimulus(input bit s, input bit a, input bit v, input logic [DATA_W-1:0] d);
    bit ready, acc, expWrEn, expDone;
    int expAddr;
    logic [DATA_W-1:0] expData;
    start    = s;
    abort    = a;
    in_valid = v;
    in_data  = d;
    #1;
    ready = mCapturing && !a;
    checkOutput("in_ready", 32'(in_ready), 32'(ready));
    acc     = v && ready;
    expWrEn = acc;
    expAddr = mIndex;
    expData = d;
    expDone = acc && (mIndex == IMG_SIZE - 1);
    if (!mCapturing && !mFinishing && s) mDrop = 0;
    else if (v && !ready && mDrop < 255) mDrop++;
    if (mFinishing) begin
      mFinishing = 1'b0;
    end else if (mCapturing) begin
      if (a) begin
        mCapturing = 1'b0;
        mIndex     = 0;
      end else if (acc) begin
        if (mIndex == IMG_SIZE - 1) begin
          mCapturing = 1'b0;
          mFinishing = 1'b1;
        end else begin
          mIndex++;
        end
      end
    end else if (s) begin
      mCapturing = 1'b1;
      mIndex     = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("wr_en", 32'(wr_en), 32'(expWrEn));
    if (expWrEn) begin
      checkOutput("wr_addr", 32'(wr_addr), 32'(expAddr));
      checkOutput("wr_data", 32'(wr_data), 32'(expData));
    end
    checkOutput("done", 32'(done), 32'(expDone));
    checkOutput("busy", 32'(busy), 32'(mCapturing || mFinishing));
    checkOutput("drop_count", 32'(drop_count), 32'(mDrop));
    if (wr_en === 1'b1) begin
      writesSeen++;
      if (int'(wr_addr) < IMG_SIZE) lastFrame[wr_addr] = wr_data;
    end
    if (done === 1'b1) doneSeen++;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_drop", 32'(drop_count), 32'd0);
    mCapturing = 1'b0;
    mFinishing = 1'b0;
    mIndex     = 0;
    mDrop      = 0;
    start      = 1'b0;
    abort      = 1'b0;
    in_valid   = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic clearTally();
    writesSeen = 0;
    doneSeen   = 0;
  endtask

  initial begin
    applyReset();

    // Drops while idle, cleared by start, followed by a back-to-back frame.
    clearTally();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'hAA);
    checkOutput("idle_drop3", 32'(drop_count), 32'd3);
    checkOutput("idle_no_writes", 32'(writesSeen), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("start_drop_clear", 32'(drop_count), 32'd0);
    for (int i = 0; i < IMG_SIZE; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("b2b_writes", 32'(writesSeen), 32'(IMG_SIZE));
    checkOutput("b2b_done", 32'(doneSeen), 32'd1);
    for (int i = 0; i < IMG_SIZE; i++) checkOutput("b2b_frame", 32'(lastFrame[i]), 32'(8'h10 + i));

    // Alternating valid.
    clearTally();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2 * IMG_SIZE; i++) applyStimulus(1'b0, 1'b0, (i % 2) == 0, 8'(8'h20 + i / 2));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("toggle_writes", 32'(writesSeen), 32'(IMG_SIZE));
    checkOutput("toggle_done", 32'(doneSeen), 32'd1);

    // Abort after five beats, then a fresh frame from address 0.
    clearTally();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h30 + i));
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hEE);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("abort_writes", 32'(writesSeen), 32'd5);
    checkOutput("abort_done", 32'(doneSeen), 32'd0);
    clearTally();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < IMG_SIZE; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("refill_writes", 32'(writesSeen), 32'(IMG_SIZE));
    checkOutput("refill_first", 32'(lastFrame[0]), 32'h40);

    // Reset mid-frame, then a complete frame.
    clearTally();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h50 + i));
    applyReset();
    checkOutput("midrst_done", 32'(doneSeen), 32'd0);
    clearTally();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < IMG_SIZE; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h60 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("postrst_writes", 32'(writesSeen), 32'(IMG_SIZE));
    checkOutput("postrst_done", 32'(doneSeen), 32'd1);

    // Start during capture is ignored.
    clearTally();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < IMG_SIZE; i++) applyStimulus(i == 4, 1'b0, 1'b1, 8'(8'h70 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("restart_writes", 32'(writesSeen), 32'(IMG_SIZE));
    checkOutput("restart_done", 32'(doneSeen), 32'd1);
    checkOutput("restart_last", 32'(lastFrame[IMG_SIZE-1]), 32'(8'h70 + IMG_SIZE - 1));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                    1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Drop counter saturation.
    applyReset();
    for (int i = 0; i < 260; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 8'h00);
    checkOutput("drop_saturated", 32'(drop_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 Parameters:
- IMG_W, default 96, image width in pixels.
- IMG_H, default 96, image height in pixels.
- DATA_W, default 8, pixel data width.
- ADDR_W = clog2(IMG_W*IMG_H); this is derived and not overridable.
REQ-002 Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  arms capture of one frame.
- abort  in  1  abandons the current frame.
- in_valid  in  1  upstream pixel valid.
- in_data  in  DATA_W  upstream pixel.
- in_ready  out  1  writer can accept a pixel this cycle.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W  linear buffer address, row*IMG_W+col.
- wr_data  out  DATA_W  pixel to write.
- busy  out  1  frame capture in progress.
- done  out  1  single-cycle pulse: a full frame has been written.
- drop_count  out  8  saturating count of pixels offered while not ready.

Function
REQ-003 The writer SHALL implement the states Idle, Capture and Finish.
REQ-004 Idle: start=1 SHALL move to Capture, clear the pointer to 0 and clear row/col; in_ready SHALL remain 0 in that cycle.
REQ-005 in_ready SHALL be 1 exactly when state==Capture and abort==0.
REQ-006 A beat is accepted when in_valid and in_ready are both 1; in_valid without in_ready SHALL not advance the pointer.
REQ-007 Each accepted beat SHALL appear on the next cycle as wr_en=1, wr_addr=pointer value at acceptance, wr_data=in_data at acceptance (latency 1, registered).
REQ-008 wr_en SHALL be 0 in every cycle not following an accepted beat.
REQ-009 The pointer SHALL increment by 1 per accepted beat; col SHALL wrap IMG_W-1 -> 0 and row SHALL increment on that wrap.
REQ-010 Acceptance at pointer IMG_W*IMG_H-1 SHALL move to Finish; the pointer SHALL hold and never wrap past the last address.
REQ-011 Finish SHALL last exactly one cycle: done=1 (concurrent with the last wr_en), then return to Idle.
REQ-012 busy SHALL be 1 in Capture and Finish, 0 in Idle.
REQ-013 abort=1 in Capture SHALL return to Idle next cycle with no beat accepted that cycle, no done pulse, and the pointer cleared; writes already issued are not retracted.
REQ-014 abort SHALL be ignored in Idle and Finish.
REQ-015 start SHALL be ignored in Capture and Finish; start and abort together in Idle SHALL behave as start alone.
REQ-016 drop_count SHALL increment on each cycle with in_valid=1 and in_ready=0, saturate at 255, and clear only on reset or on an Idle->Capture transition.

Reset
REQ-017 Reset assertion SHALL immediately force: state=Idle, pointer/row/col=0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, drop_count=0.
REQ-018 Reset asserted mid-frame SHALL abandon the frame with no done pulse; the first rising edge after deassertion SHALL observe state Idle.

Structure
REQ-019 The state enum and an IMG_SIZE helper constant SHALL live in the shared package pixel_pkg, together with the corresponding definitions used by the reader.
REQ-020 The row/col/pointer logic SHALL be one sub-module, pixel_coord_counter (inc, clear, last outputs), reusable by the reader.
REQ-021 All outputs except in_ready SHALL be registered.

Verification (IMG_W=4, IMG_H=3, DATA_W=8)
REQ-022 Start then 12 back-to-back valid beats with data 0x10..0x1B -> wr_addr 0..11 with matching data, one cycle after each beat; done=1 on the cycle wr_addr=11; Idle next cycle.
REQ-023 Beats with in_valid toggling 1,0,1,0 -> exactly 12 writes with contiguous addresses; done occurs once.
REQ-024 in_valid=1 for 3 cycles while Idle, then start -> drop_count=3 before start, 0 after start; no wr_en while Idle.
REQ-025 abort after 5 accepted beats -> exactly 5 writes (addr 0..4), no done, busy=0 next cycle; a new start rewrites from addr 0.
REQ-026 Reset asserted after 7 beats -> all outputs 0 immediately; after release, a full frame completes normally from addr 0.
REQ-027 start pulsed during Capture -> ignored; the pointer continues and the frame completes at addr 11.
